// File: rtl/hdb3_plug_b_polar.sv
// HDB3 encoder back end: 4-deep look-behind buffer with retroactive B insertion,
// followed by alternate-mark polarity scheduling onto bipolar rails.
module hdb3_plug_b_polar #(
    parameter logic INIT_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_en,
    input  logic [1:0] data_plug_v,
    output logic [1:0] sym_out,
    output logic       data_p,
    output logic       data_n,
    output logic       out_valid,
    output logic       err
);

    localparam logic [1:0] SYM_ZERO   = 2'b00;
    localparam logic [1:0] SYM_MARK   = 2'b01;
    localparam logic [1:0] SYM_B      = 2'b10;
    localparam logic [1:0] SYM_V      = 2'b11;
    localparam logic [1:0] IN_ILLEGAL = 2'b10;
    localparam logic [2:0] FILL_FULL  = 3'd4;

    logic [3:0][1:0] sr_p0;
    logic            parity_odd;
    logic            last_pol;
    logic [2:0]      fill;

    logic [1:0] in_sym_p0;
    logic [1:0] leave_sym_p3;
    logic       illegal;
    logic       is_v;
    logic       b_ins;
    logic       grp_bad;
    logic       pulse_on;
    logic       pulse_pol;

    // Stage p0: input decode and B / V-group decisions against the buffer
    always_comb begin
        illegal      = (data_plug_v == IN_ILLEGAL);
        in_sym_p0    = illegal ? SYM_ZERO : data_plug_v;
        is_v         = (in_sym_p0 == SYM_V);
        // An even mark count since the last V means the new V would break
        // alternation, so the oldest zero of the group is turned into a B.
        b_ins        = is_v & ~parity_odd;
        grp_bad      = is_v & ((sr_p0[0] != SYM_ZERO) | (sr_p0[1] != SYM_ZERO) |
                               (sr_p0[2] != SYM_ZERO));
        leave_sym_p3 = sr_p0[3];
        pulse_on     = (leave_sym_p3 != SYM_ZERO);
        // V repeats the previous pulse polarity; marks and B alternate it.
        pulse_pol    = (leave_sym_p3 == SYM_V) ? last_pol : ~last_pol;
    end

    // Stage p0->p3: look-behind buffer, parity and fill tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_p0      <= '0;
            parity_odd <= 1'b0;
            fill       <= 3'd0;
            err        <= 1'b0;
        end else if (in_en) begin
            sr_p0[0] <= in_sym_p0;
            sr_p0[1] <= sr_p0[0];
            sr_p0[2] <= sr_p0[1];
            sr_p0[3] <= b_ins ? SYM_B : sr_p0[2];
            if (is_v)
                parity_odd <= 1'b0;
            else if (in_sym_p0 == SYM_MARK)
                parity_odd <= ~parity_odd;
            if (fill != FILL_FULL)
                fill <= fill + 3'd1;
            if (illegal | grp_bad)
                err <= 1'b1;
        end
    end

    // Stage p3->out: polarity scheduling of the symbol leaving the buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_out   <= SYM_ZERO;
            data_p    <= 1'b0;
            data_n    <= 1'b0;
            out_valid <= 1'b0;
            last_pol  <= INIT_POL;
        end else begin
            out_valid <= in_en & (fill == FILL_FULL);
            if (in_en) begin
                sym_out <= leave_sym_p3;
                data_p  <= pulse_on & pulse_pol;
                data_n  <= pulse_on & ~pulse_pol;
                if (pulse_on)
                    last_pol <= pulse_pol;
            end
        end
    end

endmodule

// File: tb/tb_hdb3_plug_b_polar.sv
// Directed-vector bench for hdb3_plug_b_polar with hand-computed symbol and rail sequences.
module tb_hdb3_plug_b_polar;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_en = 1'b0;
    logic [1:0] data_plug_v = 2'b00;
    logic [1:0] sym_out;
    logic       data_p;
    logic       data_n;
    logic       out_valid;
    logic       err;

    int checks = 0;
    int errors = 0;

    logic [1:0] stim[$];
    logic [1:0] exp_sym[$];
    logic [1:0] exp_rail[$];
    logic [1:0] obs_sym[$];
    logic [1:0] obs_rail[$];

    hdb3_plug_b_polar #(.INIT_POL(1'b0)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_en       (in_en),
        .data_plug_v (data_plug_v),
        .sym_out     (sym_out),
        .data_p      (data_p),
        .data_n      (data_n),
        .out_valid   (out_valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset(input string tag);
        in_en = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk(tag, {2'b00, sym_out, data_p, data_n, out_valid, err}, 8'h00);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] s);
        in_en = 1'b1;
        data_plug_v = s;
        @(posedge clk);
        #1;
        if (out_valid) begin
            obs_sym.push_back(sym_out);
            obs_rail.push_back({data_p, data_n});
        end
        in_en = 1'b0;
    endtask

    task automatic idle_chk();
        logic [3:0] saved;
        saved = {sym_out, data_p, data_n};
        in_en = 1'b0;
        data_plug_v = 2'b01;
        @(posedge clk);
        #1;
        chk("idle_vld", {7'd0, out_valid}, 8'd0);
        chk("idle_hold", {4'd0, sym_out, data_p, data_n}, {4'd0, saved});
    endtask

    task automatic run_seq(input string tag, input bit gap, input logic exp_err);
        obs_sym.delete();
        obs_rail.delete();
        foreach (stim[i]) begin
            push(stim[i]);
            if (gap) idle_chk();
        end
        repeat (8) push(2'b00);
        chk({tag, "_nobs"}, 8'(obs_sym.size()), 8'(stim.size() + 8 - 4));
        for (int i = 0; i < exp_sym.size(); i++) begin
            if (i < obs_sym.size()) begin
                chk($sformatf("%s_sym%0d", tag, i), {6'd0, obs_sym[i]}, {6'd0, exp_sym[i]});
                chk($sformatf("%s_rail%0d", tag, i), {6'd0, obs_rail[i]}, {6'd0, exp_rail[i]});
            end
        end
        chk({tag, "_err"}, {7'd0, err}, {7'd0, exp_err});
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset("rst_init");
        repeat (10) begin
            in_en = 1'b0;
            data_plug_v = 2'b11;
            @(posedge clk);
            #1;
            chk("hold_idle", {2'b00, sym_out, data_p, data_n, out_valid, err}, 8'h00);
        end

        // No B: parity odd when V arrives. Rails {p,n}: 10 = +, 01 = -.
        stim     = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b11};
        exp_sym  = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b11};
        exp_rail = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b10};
        do_reset("rst_a");
        run_seq("seqA", 1'b0, 1'b0);

        // Second V with even parity: B inserted.
        stim     = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11};
        exp_sym  = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b00, 2'b11};
        exp_rail = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01};
        do_reset("rst_b");
        run_seq("seqB", 1'b0, 1'b0);

        // Same sequence with in_en gapped between symbols.
        do_reset("rst_bg");
        run_seq("seqBg", 1'b1, 1'b0);

        // Two marks leave parity even: B in the first zero.
        stim     = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11};
        exp_sym  = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
        exp_rail = '{2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10};
        do_reset("rst_c");
        run_seq("seqC", 1'b0, 1'b0);

        // Back-to-back V: second V breaks the group check and gets a B.
        stim     = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11};
        exp_sym  = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b11};
        exp_rail = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01};
        do_reset("rst_vv");
        run_seq("seqVV", 1'b0, 1'b1);

        // Illegal code sets a sticky err; 16 marks reach the rails, last one negative.
        do_reset("rst_ill");
        push(2'b10);
        chk("ill_err", {7'd0, err}, 8'd1);
        repeat (20) push(2'b01);
        chk("ill_sticky", {7'd0, err}, 8'd1);
        chk("ill_rails", {6'd0, data_p, data_n}, 8'b01);
        do_reset("rst_mid");

        // Mark directly before V fails the group check.
        push(2'b01);
        chk("mv_err0", {7'd0, err}, 8'd0);
        push(2'b11);
        chk("mv_err1", {7'd0, err}, 8'd1);
        do_reset("rst_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdb3_plug_b_polar.md
Name: hdb3_plug_b_polar

Overview:
- Second and third stages of the HDB3 encoder. Consumes the 2-bit symbol stream from the V-insertion stage and holds it in a 4-deep look-behind buffer.
- Retroactively converts the first zero of a 0000 group into a B pulse when required, then schedules pulse polarity onto bipolar rails.
- Sequences the encoder output path, so every encoder channel instantiates one directly after V insertion.

Parameters:
- INIT_POL, 1'b0: polarity of the virtual pulse before the first output pulse. 0 = negative, so the first pulse is positive.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_en  in  1  symbol strobe; the buffer and output advance only in cycles where in_en=1.
- data_plug_v  in  2  input symbol: 00 zero, 01 mark, 11 V, 10 illegal.
- sym_out  out  2  output symbol after B insertion: 00 zero, 01 mark, 10 B, 11 V.
- data_p  out  1  positive rail.
- data_n  out  1  negative rail.
- out_valid  out  1  outputs carry a real (non-fill) symbol this cycle.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, rst=1):
  - buffer sr[0..3] = 00, parity = even, last_pol = INIT_POL, fill = 0.
  - sym_out = 00, data_p = 0, data_n = 0, out_valid = 0, err = 0.
- Hold: with in_en=0, all state and outputs hold, except out_valid, which drops to 0 the next cycle.
- Shift (in_en=1, one cycle):
  - sr[0] <= input; sr[k] <= sr[k-1] for k = 1..2.
  - sr[3] <= sr[2], unless B insertion applies.
  - sr[3] is consumed by the output stage on the same edge.
- Parity:
  - Toggles on each input 01.
  - Resets to even on each input 11, after the B decision below.
  - An inserted B never affects parity.
- B insertion: on a shift with input 11 and parity even, sr[2] is replaced by 10 as it moves to sr[3].
  - sr[2] is the first zero of that 0000 group.
  - With parity odd, no replacement.
- V-group check: on a shift with input 11, sr[0], sr[1] and sr[2] must all be 00; otherwise set err. Insertion still proceeds per the parity rule.
- Illegal code: input 10 sets err and is treated as 00.
- err clears only on rst.
- Output stage, registered on each shift, from the symbol leaving sr[3]:
  - 01 or 10: pulse polarity = ~last_pol, then last_pol <= that polarity.
  - 11: pulse polarity = last_pol; last_pol unchanged, so V repeats the previous pulse polarity.
  - 00: data_p = 0, data_n = 0.
  - Positive pulse: data_p=1, data_n=0. Negative pulse: data_p=0, data_n=1. data_p and data_n are never both 1.
  - sym_out = symbol leaving sr[3].
- Latency: an input accepted on shift k appears on the outputs after shift k+4, i.e. during the cycle following that edge.
- fill:
  - Saturating 0..4, increments per shift.
  - out_valid <= in_en & (fill==4) on each edge, where fill is the value before the increment.
  - The 4 reset-fill zeros emerge on the outputs with out_valid=0.
- Simultaneous events:
  - Back-to-back V (11,11): the second V has parity even and fails the V-group check. err is set, sr[2] becomes B, and encoding continues.
  - A V at the first shifts after reset uses the reset zeros for the check, which passes.
- Reset mid-operation: the buffer contents are discarded and no partial output is produced. The next symbol follows the power-on rules.

Test Plan:
- Reset then no stimulus: all outputs 0, err=0. Hold in_en=0 for 10 cycles: no output change.
- Stimulus after reset, in_en=1 continuous: 01,00,00,00,11 then 8×00.
  - Required sym_out on valid cycles: 01,00,00,00,11.
  - Required rails: +,0,0,0,+ (no B, parity odd).
- Stimulus: 01,00,00,00,11,00,00,00,11 then 8×00.
  - Required sym_out: 01,00,00,00,11,10,00,00,11.
  - Required rails: +,0,0,0,+,−,0,0,−.
- Stimulus: 01,01,00,00,00,11.
  - Required sym_out: 01,01,10,00,00,11.
  - Required rails: +,−,+,0,0,+.
- Stimulus: in_en toggled 1,0,1,0 during the second scenario: output sequence identical to the continuous run; out_valid pulses only after enabled shifts.
- Error cases:
  - Input 10 sets err=1, and err stays set through 20 further symbols until rst.
  - Input 01,11 sets err=1.
  - Asserting rst mid-stream clears err and all outputs asynchronously.
